led_scan_arbiter: RTL and testbench
===================================

Name: led_scan_arbiter

Overview:
- Owns the 8-digit common-anode 7-segment display and shares it between two requesters, e.g. the countdown timer and a message/ID source.
- Arbitrates display ownership at frame boundaries, using round-robin with a minimum hold time.
- Snapshots the owner's digit codes once per frame and drives the time-multiplexed digit scan and segment outputs.
- Sits between the application counters and the board display pins.

Parameters:
- SCAN_TICKS, 200000, clk cycles per digit slot (2 ms at 100 MHz); must be >= 2.
- HOLD_FRAMES, 4, minimum frames an owner keeps the display once granted while another requester waits; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  display request, one bit per requester; level-sensitive
- digits0  in  32  requester 0 digit codes; [3:0] is digit 0 (rightmost), [31:28] is digit 7
- digits1  in  32  requester 1 digit codes, same layout
- mask0  in  8  requester 0 digit enables; 1 = lit
- mask1  in  8  requester 1 digit enables
- grant  out  2  one-hot current owner; 2'b00 when idle
- led_en  out  8  digit enables, active-low
- led_seg  out  7  segments {cg,cf,ce,cd,cc,cb,ca}, active-low
- led_dp  out  1  decimal point, active-low

Behaviour:
- Reset values: grant=2'b00, led_en=8'hFF, led_seg=7'h7F, led_dp=1, state=IDLE, slot counter=0, digit index=0, hold counter=0, rr pointer=0.
- States: IDLE and SCAN.
- IDLE:
  - All outputs are blank.
  - When req != 0 at a rising edge, the next edge registers grant; rr pointer=0 favours req[0] if both request.
  - On that same edge: snapshot the owner's digits/mask, set index=0, slot counter=0, hold=0, enter SCAN.
- SCAN:
  - Slot counter runs 0..SCAN_TICKS-1.
  - At terminal count the index advances mod 8 and the counter wraps.
  - led_en, led_seg and led_dp are registered from the same index on the same edge. No segment/enable skew is allowed.
  - led_en = ~(1<<index) if the snapshot mask bit is 1; otherwise 8'hFF for that slot.
- Frame boundary is terminal count with index=7. Arbitration happens only here; grant never changes mid-frame. At the boundary:
  - No req: go to IDLE, grant=0, outputs blank on the next edge.
  - Owner requesting, other not: keep the grant; hold saturates.
  - Other requesting and (owner not requesting or hold >= HOLD_FRAMES-1): switch grant to the other requester, hold=0, toggle rr pointer.
  - Otherwise keep the grant and increment hold.
  - In every non-IDLE case, re-snapshot from the (new) owner and set index=0.
- Owner drops req mid-frame: the frame completes from the snapshot. Input changes mid-frame are invisible until the next boundary.
- Decode, per 4-bit code:
  - 0-9: standard digits (e.g. 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'h00).
  - A: dash (7'b0111111).
  - B-E: letters b, C, d, E.
  - F: blank (7'h7F).
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro: LED_SCAN_DP_EN.
- Defined:
  - Adds inputs dp0[7:0] and dp1[7:0] (1 = point lit); these are snapshotted with the digits.
  - led_dp = ~dp_snapshot[index] during lit slots, 1 otherwise.
- Undefined: ports absent, led_dp constant 1.

Decomposition:
- Shared package led_disp_pkg:
  - Segment constants SEG_BLANK, SEG_DASH and SEG_DIGIT[0:15].
  - NUM_DIGITS=8, DIGIT_W=4.
  - State encoding IDLE/SCAN.
- One combinational sub-module, seg7_decode (4-bit code -> 7-bit active-low segments). It is reused by other display blocks.

Test Plan (SCAN_TICKS=4, HOLD_FRAMES=2):
- Reset release with req=0 -> grant=00, led_en=FF, led_seg=7F held for 100 cycles.
- req=01, digits0=32'h76543210, mask0=FF -> grant=01 one edge later. led_en walks FE, FD, … 7F, each for 4 cycles. Slot 0 shows seg 7'b1000000; slot 7 shows the decode of 7.
- mask0=8'b1111_0000 -> slots 0-3 have led_en=FF; slots 4-7 are lit normally.
- req=11 from idle -> grant=01 for exactly 2 frames (64 cycles), then 10 for 2 frames, then alternates. Never switches at index != 7.
- Owner req drops at frame cycle 10 with the other idle -> the frame completes (32 cycles total), then grant=00 and led_en=FF. digits0 changed mid-frame is not displayed.
- rst_n pulsed low mid-slot -> outputs are at reset values before the next clk edge. Re-grant follows normal IDLE timing after release.

Source files
------------

// File: rtl/led_disp_pkg.sv
// led_disp_pkg: shared 7-segment display constants, sizes and scan state encoding
package led_disp_pkg;
  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_DASH, 7'h03, 7'h46, 7'h21, 7'h06, SEG_BLANK
  };
  typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit display code to active-low {g,f,e,d,c,b,a} segments
module seg7_decode
  import led_disp_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);
  assign o_seg = SEG_DIGIT[i_code];
endmodule

// File: rtl/led_scan_arbiter.sv
// led_scan_arbiter: frame-aligned round-robin sharing of an 8-digit display; LED_SCAN_DP_EN adds decimal points
module led_scan_arbiter
  import led_disp_pkg::*;
#(
  parameter int SCAN_TICKS  = 200000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [31:0] digits0,
  input  logic [31:0] digits1,
  input  logic [7:0]  mask0,
  input  logic [7:0]  mask1,
`ifdef LED_SCAN_DP_EN
  input  logic [7:0]  dp0,
  input  logic [7:0]  dp1,
`endif
  output logic [1:0]  grant,
  output logic [7:0]  led_en,
  output logic [6:0]  led_seg,
  output logic        led_dp
);
  localparam int CW = $clog2(SCAN_TICKS);
  localparam int HW = HOLD_FRAMES > 1 ? $clog2(HOLD_FRAMES) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [HW-1:0]   r_hold, w_hold_nxt;
  logic            r_rr, w_rr_nxt;
  logic [1:0]      r_grant, w_grant_nxt;
  logic [31:0]     r_digits, w_digits_nxt;
  logic [7:0]      r_mask, w_mask_nxt;
  logic [7:0]      r_en;
  logic [6:0]      r_seg;
  logic            w_load, w_pick, w_own, w_tc, w_frame_end, w_hold_max, w_lit;
  logic [3:0]      w_code;
  logic [6:0]      w_seg;

  assign w_tc        = r_cnt == CW'(SCAN_TICKS - 1);
  assign w_frame_end = w_tc && r_idx == IW'(NUM_DIGITS - 1);
  assign w_own       = r_grant[1];
  assign w_hold_max  = r_hold >= HW'(HOLD_FRAMES - 1);

  // Next-state, counters and frame-boundary arbitration
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    w_rr_nxt    = r_rr;
    w_grant_nxt = r_grant;
    w_load      = 1'b0;
    w_pick      = 1'b0;
    if (r_state == IDLE) begin
      if (|req) begin
        w_state_nxt = SCAN;
        w_pick      = req[1] && (!req[0] || r_rr);
        w_grant_nxt = w_pick ? 2'b10 : 2'b01;
        w_load      = 1'b1;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_hold_nxt  = '0;
      end
    end else begin
      w_cnt_nxt = w_tc ? '0 : r_cnt + 1'b1;
      w_idx_nxt = w_tc ? r_idx + 1'b1 : r_idx;
      if (w_frame_end) begin
        if (~|req) begin
          w_state_nxt = IDLE;
          w_grant_nxt = 2'b00;
        end else if (req[~w_own] && (!req[w_own] || w_hold_max)) begin
          w_grant_nxt = ~r_grant;
          w_hold_nxt  = '0;
          w_rr_nxt    = ~r_rr;
          w_load      = 1'b1;
          w_pick      = ~w_own;
        end else begin
          w_hold_nxt = w_hold_max ? r_hold : r_hold + 1'b1;
          w_load     = 1'b1;
          w_pick     = w_own;
        end
      end
    end
  end

  assign w_digits_nxt = w_load ? (w_pick ? digits1 : digits0) : r_digits;
  assign w_mask_nxt   = w_load ? (w_pick ? mask1 : mask0) : r_mask;
  assign w_lit        = w_state_nxt == SCAN && w_mask_nxt[w_idx_nxt];
  assign w_code       = w_digits_nxt[{w_idx_nxt, 2'b00} +: DIGIT_W];

  seg7_decode u_dec (
    .i_code (w_code),
    .o_seg  (w_seg)
  );

  // State, snapshot and outputs, all registered from the next index so enable and segments never skew
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_hold   <= '0;
      r_rr     <= 1'b0;
      r_grant  <= 2'b00;
      r_digits <= '0;
      r_mask   <= '0;
      r_en     <= 8'hFF;
      r_seg    <= SEG_BLANK;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_hold   <= w_hold_nxt;
      r_rr     <= w_rr_nxt;
      r_grant  <= w_grant_nxt;
      r_digits <= w_digits_nxt;
      r_mask   <= w_mask_nxt;
      r_en     <= w_lit ? ~(8'd1 << w_idx_nxt) : 8'hFF;
      r_seg    <= w_lit ? w_seg : SEG_BLANK;
    end
  end

`ifdef LED_SCAN_DP_EN
  logic [7:0] r_dp, w_dp_nxt;
  logic       r_dp_out;
  assign w_dp_nxt = w_load ? (w_pick ? dp1 : dp0) : r_dp;
  // Decimal-point snapshot and output, aligned with the digit scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp     <= '0;
      r_dp_out <= 1'b1;
    end else begin
      r_dp     <= w_dp_nxt;
      r_dp_out <= !(w_lit && w_dp_nxt[w_idx_nxt]);
    end
  end
  assign led_dp = r_dp_out;
`else
  assign led_dp = 1'b1;
`endif

  assign grant   = r_grant;
  assign led_en  = r_en;
  assign led_seg = r_seg;
endmodule

// File: tb/tb_led_scan_arbiter.sv
// tb_led_scan_arbiter: table vectors, hand sequences and random traffic against a frame-level reference model
module tb_led_scan_arbiter;
  localparam int ST = 4;
  localparam int HF = 2;
  localparam int FR = ST * 8;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [1:0]  req = 0;
  logic [31:0] digits0 = 0, digits1 = 0;
  logic [7:0]  mask0 = 0, mask1 = 0;
  logic [1:0]  grant;
  logic [7:0]  led_en;
  logic [6:0]  led_seg;
  logic        led_dp;
`ifdef LED_SCAN_DP_EN
  logic [7:0]  dp0 = 0, dp1 = 0;
`endif

  int total = 0, bad = 0;

  typedef struct {logic [3:0] code; logic [6:0] seg;} dec_t;
  dec_t tbl [16];

  bit          m_act;
  int          m_own, m_hold, m_rr, m_p;
  logic [31:0] m_dig;
  logic [7:0]  m_msk;

  always #5 clk = ~clk;

  led_scan_arbiter #(.SCAN_TICKS(ST), .HOLD_FRAMES(HF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .digits0 (digits0),
    .digits1 (digits1),
    .mask0   (mask0),
    .mask1   (mask1),
`ifdef LED_SCAN_DP_EN
    .dp0     (dp0),
    .dp1     (dp1),
`endif
    .grant   (grant),
    .led_en  (led_en),
    .led_seg (led_seg),
    .led_dp  (led_dp)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic snap();
    m_dig = m_own ? digits1 : digits0;
    m_msk = m_own ? mask1 : mask0;
  endtask

  task automatic model_reset();
    m_act = 0; m_own = 0; m_hold = 0; m_rr = 0; m_p = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_act) begin
      if (req != 0) begin
        m_act = 1;
        m_own = (req == 2'b11) ? m_rr : int'(req[1]);
        m_p = 0; m_hold = 0;
        snap();
      end
    end else if (m_p == FR - 1) begin
      if (req == 0) m_act = 0;
      else begin
        if (req[1-m_own] && (!req[m_own] || m_hold >= HF - 1)) begin
          m_own = 1 - m_own; m_hold = 0; m_rr ^= 1;
        end else if (m_hold < HF - 1) m_hold++;
        m_p = 0;
        snap();
      end
    end else m_p++;
  endtask

  task automatic compare_all();
    int s;
    logic lit;
    logic [7:0] e;
    logic [1:0] g;
    s = m_p / ST;
    lit = m_act && m_msk[s];
    e = lit ? ~(8'd1 << s) : 8'hFF;
    g = m_act ? (2'd1 << m_own) : 2'd0;
    chk("grant", grant, g);
    chk("led_en", led_en, e);
    if (lit || !m_act) chk("led_seg", led_seg, lit ? tbl[m_dig[s*4 +: 4]].seg : 7'h7F);
    chk("led_dp", led_dp, 1'b1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic to_boundary();
    for (int i = 0; i < 2 * FR && !(m_act && m_p == FR - 1); i++) cyc();
    total++;
    if (!(m_act && m_p == FR - 1)) begin
      bad++;
      $display("FAIL boundary_wait act_grant=%b exp=frame_end", grant);
    end
  endtask

  initial begin
    logic [31:0] dig;
    int n;
    tbl = '{'{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
            '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
            '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h3F}, '{4'hB, 7'h03},
            '{4'hC, 7'h46}, '{4'hD, 7'h21}, '{4'hE, 7'h06}, '{4'hF, 7'h7F}};
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_en", led_en, 8'hFF);
    chk("rst_seg", led_seg, 7'h7F);
    chk("rst_dp", led_dp, 1'b1);
    rst_n = 1;
    repeat (100) cyc();

    digits0 = 32'h76543210; mask0 = 8'hFF; req = 2'b01;
    cyc();
    chk("grant_latency", grant, 2'b01);
    chk("slot0_seg", led_seg, 7'b1000000);
    chk("slot0_en", led_en, 8'hFE);
    repeat (FR - 1) cyc();
    chk("slot7_seg", led_seg, 7'b1111000);
    chk("slot7_en", led_en, 8'h7F);

    mask0 = 8'hF0;
    repeat (2 * FR) cyc();
    mask0 = 8'hFF;

    for (int f = 0; f < 2; f++) begin
      to_boundary();
      for (int i = 0; i < 8; i++) dig[i*4 +: 4] = tbl[8*f+i].code;
      digits0 = dig;
      cyc();
      for (int s = 0; s < 8; s++) begin
        chk($sformatf("decode_%h", tbl[8*f+s].code), led_seg, tbl[8*f+s].seg);
        repeat (ST) cyc();
      end
    end

    req = 2'b00;
    to_boundary();
    cyc();
    chk("idle_grant", grant, 2'b00);
    chk("idle_en", led_en, 8'hFF);

    digits1 = 32'hABCDE987; mask1 = 8'h5A; req = 2'b11;
    for (int k = 0; k < 192; k++) begin
      cyc();
      chk("rr_grant", grant, (k < 64) ? 2'b01 : (k < 128) ? 2'b10 : 2'b01);
    end

    req = 2'b00;
    to_boundary();
    cyc();
    digits0 = 32'h12345678; mask0 = 8'hFF; req = 2'b01;
    cyc();
    n = 1;
    repeat (10) begin
      cyc();
      n++;
    end
    req = 2'b00; digits0 = 32'h88888888;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (grant == 2'b00) break;
      n++;
    end
    chk("drop_frame_len", n, FR);
    chk("drop_en", led_en, 8'hFF);

    req = 2'b01;
    repeat (6) cyc();
    #2 rst_n = 0;
    #1;
    chk("async_grant", grant, 2'b00);
    chk("async_en", led_en, 8'hFF);
    chk("async_seg", led_seg, 7'h7F);
    chk("async_dp", led_dp, 1'b1);
    model_reset();
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    chk("regrant", grant, 2'b01);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) req = 2'($urandom);
      digits0 = $urandom;
      digits1 = $urandom;
      if ($urandom_range(0, 7) == 0) mask0 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) mask1 = 8'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
